// File: rtl/axi4_lite_read_collector.sv
// Collects the N beats of a wrapped (critical-word-first) AXI4-lite read and
// presents the block in address order, with a sticky error flag, to the consumer.
module axi4_lite_read_collector #(
  parameter int words_per_block_p = 8,
  parameter int axi_addr_width_p  = 28,
  parameter int axi_data_width_p  = 64
) (
  input  logic                                           clk_i,
  input  logic                                           reset_n_i,
  input  logic [axi_addr_width_p-1:0]                    addr_i,
  input  logic                                           addr_v_i,
  output logic                                           addr_ready_and_o,
  input  logic [axi_data_width_p-1:0]                    r_data_i,
  input  logic [1:0]                                     r_resp_i,
  input  logic                                           r_v_i,
  output logic                                           r_ready_and_o,
  output logic [words_per_block_p*axi_data_width_p-1:0]  data_o,
  output logic                                           err_o,
  output logic                                           v_o,
  input  logic                                           ready_and_i
);

  localparam int off_w_lp = $clog2(axi_data_width_p/8);
  localparam int idx_w_lp = (words_per_block_p > 1) ? $clog2(words_per_block_p) : 1;
  localparam logic [idx_w_lp-1:0] last_cnt_lp = idx_w_lp'(words_per_block_p - 1);

  localparam logic [1:0] e_idle    = 2'd0;
  localparam logic [1:0] e_collect = 2'd1;
  localparam logic [1:0] e_send    = 2'd2;

  logic [1:0]          state_r;
  logic [1:0]          state_next_s;
  logic [idx_w_lp-1:0] cnt_r;
  logic [idx_w_lp-1:0] idx_r;
  logic [idx_w_lp-1:0] word_idx_s;
  logic                err_r;
  logic                addr_ready_r;
  logic                r_ready_r;
  logic                v_r;
  logic                req_s;
  logic                beat_s;
  logic                last_beat_s;
  logic                unused_addr_s;
  logic [words_per_block_p-1:0][axi_data_width_p-1:0] block_r;

  // Only the word-index bits of the address matter; the rest is folded away.
  assign unused_addr_s = ^addr_i;

  generate
    if (words_per_block_p > 1) begin : g_word_idx
      assign word_idx_s = addr_i[off_w_lp +: idx_w_lp];
    end else begin : g_word_idx_single
      assign word_idx_s = {idx_w_lp{1'b0}};
    end
  endgenerate

  assign req_s       = (state_r == e_idle) && addr_v_i && addr_ready_r;
  assign beat_s      = (state_r == e_collect) && r_v_i && r_ready_r;
  assign last_beat_s = beat_s && (cnt_r == last_cnt_lp);

  // Next-state selection; any unknown encoding falls back to idle.
  always_comb begin
    state_next_s = e_idle;
    case (state_r)
      e_idle: begin
        if (req_s) state_next_s = e_collect;
        else       state_next_s = e_idle;
      end
      e_collect: begin
        if (last_beat_s) state_next_s = e_send;
        else             state_next_s = e_collect;
      end
      e_send: begin
        if (v_r && ready_and_i) state_next_s = e_idle;
        else                    state_next_s = e_send;
      end
      default: state_next_s = e_idle;
    endcase
  end

  // State, counters, sticky error and registered handshake outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_idle;
      cnt_r        <= {idx_w_lp{1'b0}};
      idx_r        <= {idx_w_lp{1'b0}};
      err_r        <= 1'b0;
      addr_ready_r <= 1'b0;
      r_ready_r    <= 1'b0;
      v_r          <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      addr_ready_r <= (state_next_s == e_idle);
      r_ready_r    <= (state_next_s == e_collect);
      v_r          <= (state_next_s == e_send);
      if (req_s) begin
        idx_r <= word_idx_s;
        cnt_r <= {idx_w_lp{1'b0}};
        err_r <= 1'b0;
      end else if (beat_s) begin
        // Wrapping index; a one-word block always stays at slot 0.
        idx_r <= (words_per_block_p == 1) ? {idx_w_lp{1'b0}} : idx_r + idx_w_lp'(1);
        cnt_r <= last_beat_s ? {idx_w_lp{1'b0}} : cnt_r + idx_w_lp'(1);
        err_r <= err_r | (r_resp_i != 2'b00);
      end
    end
  end

  // Block register: each accepted beat lands in its word slot.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      block_r <= {(words_per_block_p*axi_data_width_p){1'b0}};
    end else if (beat_s) begin
      for (int i = 0; i < words_per_block_p; i++) begin
        if (idx_r == idx_w_lp'(i)) block_r[i] <= r_data_i;
      end
    end
  end

  assign addr_ready_and_o = addr_ready_r;
  assign r_ready_and_o    = r_ready_r;
  assign v_o              = v_r;
  assign err_o            = err_r;
  assign data_o           = block_r;

endmodule

// File: tb/tb_axi4_lite_read_collector.sv
// Directed bench for axi4_lite_read_collector: an 8-word instance plus a
// single-word instance sharing clock and reset.
module tb_axi4_lite_read_collector;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 8-word instance
  logic [27:0]      addr = 28'h0;
  logic             addr_v = 1'b0;
  logic             addr_ready;
  logic [63:0]      r_data = 64'h0;
  logic [1:0]       r_resp = 2'b00;
  logic             r_v = 1'b0;
  logic             r_ready;
  logic [8*64-1:0]  data;
  logic             err;
  logic             v;
  logic             ready = 1'b0;

  // 1-word instance
  logic [27:0]      addr1 = 28'h0;
  logic             addr_v1 = 1'b0;
  logic             addr_ready1;
  logic [63:0]      r_data1 = 64'h0;
  logic             r_v1 = 1'b0;
  logic             r_ready1;
  logic [63:0]      data1;
  logic             err1;
  logic             v1;
  logic             ready1 = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0][63:0] exp_blk;

  axi4_lite_read_collector #(.words_per_block_p(8), .axi_addr_width_p(28), .axi_data_width_p(64)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .addr_i(addr), .addr_v_i(addr_v), .addr_ready_and_o(addr_ready),
    .r_data_i(r_data), .r_resp_i(r_resp), .r_v_i(r_v), .r_ready_and_o(r_ready),
    .data_o(data), .err_o(err), .v_o(v), .ready_and_i(ready)
  );

  axi4_lite_read_collector #(.words_per_block_p(1), .axi_addr_width_p(28), .axi_data_width_p(64)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n),
    .addr_i(addr1), .addr_v_i(addr_v1), .addr_ready_and_o(addr_ready1),
    .r_data_i(r_data1), .r_resp_i(2'b00), .r_v_i(r_v1), .r_ready_and_o(r_ready1),
    .data_o(data1), .err_o(err1), .v_o(v1), .ready_and_i(ready1)
  );

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the address handshake.
  task automatic send_req(input logic [27:0] a);
    int n = 0;
    addr = a;
    addr_v = 1'b1;
    while (!addr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("req_timeout", 512'd1, 512'd0);
    @(negedge clk);
    addr_v = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the R handshake.
  task automatic send_beat(input logic [63:0] d, input logic [1:0] resp);
    int n = 0;
    r_data = d;
    r_resp = resp;
    r_v = 1'b1;
    while (!r_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("beat_timeout", 512'd1, 512'd0);
    @(negedge clk);
    r_v = 1'b0;
    r_resp = 2'b00;
  endtask

  // Checks the presented block then completes the block handshake.
  task automatic take_block(input string tag, input logic [511:0] exp_data, input logic exp_err);
    check_val({tag, "_v"}, {511'd0, v}, 512'd1);
    check_val({tag, "_data"}, data, exp_data);
    check_val({tag, "_err"}, {511'd0, err}, {511'd0, exp_err});
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check_val({tag, "_v_drop"}, {511'd0, v}, 512'd0);
  endtask

  initial begin
    int gaps [8];
    gaps = '{0, 2, 1, 3, 0, 1, 2, 0};

    // Reset state
    #2;
    check_val("rst_v", {511'd0, v}, 512'd0);
    check_val("rst_addr_ready", {511'd0, addr_ready}, 512'd0);
    check_val("rst_r_ready", {511'd0, r_ready}, 512'd0);
    check_val("rst_data", data, 512'd0);
    check_val("rst_err", {511'd0, err}, 512'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("idle_addr_ready", {511'd0, addr_ready}, 512'd1);
    check_val("idle_r_ready", {511'd0, r_ready}, 512'd0);

    // Critical word 5: beats 0x10..0x17 land in slots 5,6,7,0..4
    send_req(28'h028);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check_val("t1_v_early", {511'd0, v}, 512'd0);
      send_beat(64'h10 + 64'(k), 2'b00);
    end
    exp_blk = {64'h12, 64'h11, 64'h10, 64'h17, 64'h16, 64'h15, 64'h14, 64'h13};
    take_block("t1", exp_blk, 1'b0);

    // Aligned with gaps between beats
    @(negedge clk);
    send_req(28'h000);
    for (int k = 0; k < 8; k++) begin
      repeat (gaps[k]) @(negedge clk);
      if (k == 7) check_val("t2_v_early", {511'd0, v}, 512'd0);
      send_beat(64'h20 + 64'(k), 2'b00);
    end
    exp_blk = {64'h27, 64'h26, 64'h25, 64'h24, 64'h23, 64'h22, 64'h21, 64'h20};
    take_block("t2", exp_blk, 1'b0);

    // Error on beat 3, block still complete
    @(negedge clk);
    send_req(28'h000);
    for (int k = 0; k < 8; k++) send_beat(64'h30 + 64'(k), (k == 3) ? 2'b10 : 2'b00);
    exp_blk = {64'h37, 64'h36, 64'h35, 64'h34, 64'h33, 64'h32, 64'h31, 64'h30};
    take_block("t3a", exp_blk, 1'b1);

    // Next block all OKAY from word 2: sticky error cleared
    @(negedge clk);
    send_req(28'h010);
    for (int k = 0; k < 8; k++) send_beat(64'h40 + 64'(k), 2'b00);
    exp_blk = {64'h45, 64'h44, 64'h43, 64'h42, 64'h41, 64'h40, 64'h47, 64'h46};
    take_block("t3b", exp_blk, 1'b0);

    // Consumer stall with pending R beat and address request
    @(negedge clk);
    send_req(28'h000);
    for (int k = 0; k < 8; k++) send_beat(64'h60 + 64'(k), 2'b00);
    exp_blk = {64'h67, 64'h66, 64'h65, 64'h64, 64'h63, 64'h62, 64'h61, 64'h60};
    r_v = 1'b1;
    r_data = 64'hDEAD;
    addr = 28'h000;
    addr_v = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_val("t4_r_ready", {511'd0, r_ready}, 512'd0);
      check_val("t4_addr_ready", {511'd0, addr_ready}, 512'd0);
      check_val("t4_v_hold", {511'd0, v}, 512'd1);
      check_val("t4_data_hold", data, exp_blk);
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    r_v = 1'b0;
    check_val("t4_v_drop", {511'd0, v}, 512'd0);
    check_val("t4_addr_ready_back", {511'd0, addr_ready}, 512'd1);
    @(negedge clk);
    addr_v = 1'b0;
    check_val("t4_req_taken", {511'd0, addr_ready}, 512'd0);
    check_val("t4_collecting", {511'd0, r_ready}, 512'd1);

    // Reset after 4 of 8 beats
    for (int k = 0; k < 4; k++) send_beat(64'h70 + 64'(k), 2'b01);
    reset_n = 1'b0;
    #1;
    check_val("t5_rst_v", {511'd0, v}, 512'd0);
    check_val("t5_rst_r_ready", {511'd0, r_ready}, 512'd0);
    check_val("t5_rst_addr_ready", {511'd0, addr_ready}, 512'd0);
    check_val("t5_rst_data", data, 512'd0);
    check_val("t5_rst_err", {511'd0, err}, 512'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("t5_addr_ready", {511'd0, addr_ready}, 512'd1);
    send_req(28'h038);
    for (int k = 0; k < 8; k++) send_beat(64'h50 + 64'(k), 2'b00);
    exp_blk = {64'h50, 64'h57, 64'h56, 64'h55, 64'h54, 64'h53, 64'h52, 64'h51};
    take_block("t5", exp_blk, 1'b0);

    // Single-word build
    check_val("t6_addr_ready", {511'd0, addr_ready1}, 512'd1);
    addr1 = 28'h008;
    addr_v1 = 1'b1;
    @(negedge clk);
    addr_v1 = 1'b0;
    check_val("t6_r_ready", {511'd0, r_ready1}, 512'd1);
    r_data1 = 64'hAB;
    r_v1 = 1'b1;
    @(negedge clk);
    r_v1 = 1'b0;
    check_val("t6_v", {511'd0, v1}, 512'd1);
    check_val("t6_data", {448'd0, data1}, 512'hAB);
    check_val("t6_err", {511'd0, err1}, 512'd0);
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    check_val("t6_v_drop", {511'd0, v1}, 512'd0);
    check_val("t6_addr_ready_back", {511'd0, addr_ready1}, 512'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
